// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit BHT branch predictor with EX-stage resolution and statistics
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             branch,
    input  logic [2:0]       br_type,
    input  logic [XLEN-1:0]  rs_a,
    input  logic [XLEN-1:0]  rs_b,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             take_branch,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5
    } br_type_e;

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             resolve;
    logic             cond;
    logic             wrong;
    logic [1:0]       ex_entry;

    // Word-aligned PCs: the two low bits carry no index information
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    assign resolve = ex_valid & branch & (br_type <= 3'd5);

    always_comb begin
        cond = 1'b0;
        case (br_type)
            BR_BEQ:  cond = (rs_a == rs_b);
            BR_BNE:  cond = (rs_a != rs_b);
            BR_BLT:  cond = ($signed(rs_a) <  $signed(rs_b));
            BR_BGE:  cond = ($signed(rs_a) >= $signed(rs_b));
            BR_BLTU: cond = (rs_a <  rs_b);
            BR_BGEU: cond = (rs_a >= rs_b);
            default: cond = 1'b0;
        endcase
    end

    assign take_branch = resolve & cond;
    assign wrong       = resolve & (take_branch != ex_pred_taken);
    assign ex_entry    = bht[ex_idx];

    // Read before the clocked update, so a same-index lookup sees the old counter
    assign pred_taken = bht[if_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
            mispredict <= 1'b0;
            br_count   <= '0;
            mp_count   <= '0;
        end else begin
            mispredict <= wrong;
            if (resolve) begin
                if (take_branch) begin
                    if (ex_entry != 2'b11) bht[ex_idx] <= ex_entry + 2'd1;
                end else begin
                    if (ex_entry != 2'b00) bht[ex_idx] <= ex_entry - 2'd1;
                end
                if (br_count != {CNT_W{1'b1}}) br_count <= br_count + CNT_W'(1);
            end
            // mp_count only advances alongside a resolve, so it can never pass br_count
            if (wrong && (mp_count != {CNT_W{1'b1}})) begin
                mp_count <= mp_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [XLEN-1:0]  if_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             branch;
    logic [2:0]       br_type;
    logic [XLEN-1:0]  rs_a;
    logic [XLEN-1:0]  rs_b;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic             take_branch;
    logic             mispredict;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .branch(branch), .br_type(br_type),
        .rs_a(rs_a), .rs_b(rs_b), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .take_branch(take_branch), .mispredict(mispredict),
        .br_count(br_count), .mp_count(mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic pt);
        ex_valid = 1'b1; branch = 1'b1; br_type = t;
        rs_a = a; rs_b = b; ex_pc = pc; ex_pred_taken = pt;
    endtask

    task automatic do_resolve(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic pt);
        drive(t, a, b, pc, pt);
        tick();
        ex_valid = 1'b0; branch = 1'b0;
    endtask

    logic exp_pred [6];
    logic exp_mp   [6];

    initial begin
        rst = 1'b1; if_pc = '0; ex_valid = 1'b0; branch = 1'b0; br_type = 3'd0;
        rs_a = '0; rs_b = '0; ex_pc = '0; ex_pred_taken = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_eq("rst_pred_0x0", pred_taken, 0);
        if_pc = 32'h3C; #1;
        check_eq("rst_pred_0x3c", pred_taken, 0);
        check_eq("rst_mispredict", mispredict, 0);
        check_eq("rst_br_count", br_count, 0);
        check_eq("rst_mp_count", mp_count, 0);

        // BEQ taken, predicted not-taken at 0x40
        if_pc = 32'h40;
        drive(3'd0, 5, 5, 32'h40, 1'b0);
        #1;
        check_eq("beq_take", take_branch, 1);
        check_eq("beq_pred_before", pred_taken, 0);
        tick();
        ex_valid = 1'b0; branch = 1'b0; #1;
        check_eq("beq_mispredict", mispredict, 1);
        check_eq("beq_mp_count", mp_count, 1);
        check_eq("beq_br_count", br_count, 1);
        check_eq("beq_pred_after", pred_taken, 1);
        if_pc = 32'h0; #1;
        check_eq("alias_pred_0x0", pred_taken, 1);
        tick();
        check_eq("beq_mispredict_drop", mispredict, 0);

        // Compare types, evaluated combinationally without clocking
        drive(3'd2, 32'hFFFF_FFFF, 1, 32'h80, 1'b0); #1;
        check_eq("blt_neg", take_branch, 1);
        br_type = 3'd4; #1;
        check_eq("bltu_big", take_branch, 0);
        br_type = 3'd3; #1;
        check_eq("bge_neg", take_branch, 0);
        br_type = 3'd5; #1;
        check_eq("bgeu_big", take_branch, 1);
        br_type = 3'd1; rs_a = 5; rs_b = 5; #1;
        check_eq("bne_equal", take_branch, 0);
        br_type = 3'd0; ex_valid = 1'b0; #1;
        check_eq("no_valid", take_branch, 0);
        branch = 1'b0;

        // Saturating counter walk at 0x10: T,T,T,T,N,N
        exp_pred = '{1, 1, 1, 1, 1, 0};
        exp_mp   = '{0, 0, 0, 0, 1, 1};
        if_pc = 32'h10; #1;
        check_eq("walk_pred_init", pred_taken, 0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) do_resolve(3'd0, 7, 7, 32'h10, 1'b1);
            else       do_resolve(3'd0, 7, 8, 32'h10, 1'b1);
            check_eq($sformatf("walk_pred_%0d", i), pred_taken, exp_pred[i]);
            check_eq($sformatf("walk_mp_%0d", i), mispredict, exp_mp[i]);
        end
        check_eq("walk_br_count", br_count, 7);
        check_eq("walk_mp_count", mp_count, 3);

        // Reserved types do not resolve
        drive(3'd6, 7, 7, 32'h10, 1'b0); #1;
        check_eq("rsv6_take", take_branch, 0);
        tick();
        drive(3'd7, 7, 7, 32'h10, 1'b0); #1;
        check_eq("rsv7_take", take_branch, 0);
        tick();
        ex_valid = 1'b0; branch = 1'b0; #1;
        check_eq("rsv_pred", pred_taken, 0);
        check_eq("rsv_br_count", br_count, 7);
        check_eq("rsv_mp_count", mp_count, 3);
        check_eq("rsv_mispredict", mispredict, 0);

        // Reset wins over a simultaneous mispredicting resolve
        drive(3'd0, 7, 7, 32'h10, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0; ex_valid = 1'b0; branch = 1'b0; #1;
        check_eq("rstres_pred_0x10", pred_taken, 0);
        check_eq("rstres_mispredict", mispredict, 0);
        check_eq("rstres_br_count", br_count, 0);
        check_eq("rstres_mp_count", mp_count, 0);
        if_pc = 32'h40; #1;
        check_eq("rstres_pred_0x40", pred_taken, 0);

        // Counter saturation with CNT_W=4
        if_pc = 32'h20;
        for (int i = 0; i < 20; i++) begin
            do_resolve(3'd0, 3, 3, 32'h20, 1'b0);
            if (i == 14) check_eq("sat_br_at15", br_count, 15);
        end
        check_eq("sat_br_count", br_count, 15);
        check_eq("sat_mp_count", mp_count, 15);
        check_eq("sat_mispredict", mispredict, 1);
        check_eq("sat_pred", pred_taken, 1);
        tick();
        check_eq("sat_mispredict_drop", mispredict, 0);
        check_eq("sat_br_hold", br_count, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand and PC width.
REQ-002 The module SHALL have parameter BHT_ENTRIES, default 16, meaning the number of 2-bit counter entries; it SHALL be a power of 2 and at least 2.
REQ-003 The module SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port if_pc, input, XLEN bits: fetch-stage PC used for lookup.
REQ-007 The module SHALL have port pred_taken, output, 1 bit: prediction for if_pc.
REQ-008 The module SHALL have port ex_valid, input, 1 bit: the EX-stage instruction is valid.
REQ-009 The module SHALL have port branch, input, 1 bit: the EX-stage instruction is a conditional branch.
REQ-010 The module SHALL have port br_type, input, 3 bits: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU; 6 and 7 reserved.
REQ-011 The module SHALL have ports rs_a and rs_b, input, XLEN bits each: the compare operands.
REQ-012 The module SHALL have port ex_pc, input, XLEN bits: PC of the EX-stage branch.
REQ-013 The module SHALL have port ex_pred_taken, input, 1 bit: the prediction made for this branch at fetch.
REQ-014 The module SHALL have port take_branch, output, 1 bit: resolved outcome.
REQ-015 The module SHALL have port mispredict, output, 1 bit: registered flush pulse.
REQ-016 The module SHALL have ports br_count and mp_count, output, CNT_W bits each: resolved-branch and mispredict statistics.

Function
REQ-017 Define resolve = ex_valid & branch & (br_type <= 5).
REQ-018 take_branch SHALL be combinational: resolve AND the condition selected by br_type.
  - BEQ: a==b; BNE: a!=b; BLT/BGE: signed compare; BLTU/BGEU: unsigned compare.
REQ-019 take_branch SHALL be 0 whenever resolve is 0, including reserved br_type codes.
REQ-020 The index SHALL be pc[log2(BHT_ENTRIES)+1:2]; if_pc and ex_pc SHALL each be indexed this way.
REQ-021 pred_taken SHALL be combinational and equal to bit 1 of the BHT entry indexed by if_pc.
REQ-022 On each clk edge with resolve=1 and rst=0, the entry indexed by ex_pc SHALL update as a 2-bit saturating counter.
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
REQ-023 Same-cycle lookup and update to the same index: pred_taken SHALL reflect the pre-update value; the new value SHALL be visible from the next cycle.
REQ-024 With resolve=0, no BHT entry SHALL change.
REQ-025 mispredict SHALL be registered with 1-cycle latency.
  - It SHALL be 1 in the cycle after a resolve with take_branch != ex_pred_taken.
  - It SHALL be 0 otherwise.
REQ-026 br_count SHALL increment by 1 on each resolve, saturating at 2^CNT_W-1 with no wrap.
REQ-027 mp_count SHALL increment by 1 on each mispredicting resolve, saturating at 2^CNT_W-1 with no wrap.
REQ-028 mp_count SHALL never exceed br_count.

Reset
REQ-029 When rst=1 at a clk edge, all BHT entries SHALL become 01 (weakly not-taken) in that one cycle.
REQ-030 When rst=1 at a clk edge, mispredict, br_count and mp_count SHALL become 0.
REQ-031 rst SHALL take priority over a simultaneous resolve: no update and no count.
REQ-032 Reset asserted mid-operation SHALL discard any pending mispredict pulse.
REQ-033 During and after reset, pred_taken SHALL read 0 for every PC until that entry is updated.

Verification
REQ-034 Reset, then apply any if_pc -> pred_taken=0, mispredict=0, br_count=0, mp_count=0.
REQ-035 BEQ with rs_a=rs_b=5, ex_pred_taken=0, ex_pc=0x40 -> take_branch=1 the same cycle, mispredict=1 the next cycle, mp_count=1, and pred_taken for if_pc=0x40 becomes 1 next cycle.
REQ-036 BLT with rs_a=0xFFFFFFFF and rs_b=1 -> taken; BLTU with the same operands -> not taken.
REQ-037 Four taken resolves at ex_pc=0x10, then two not-taken resolves -> entry sequence 01,10,11,11,11,10,01; pred_taken follows bit 1 of the entry.
REQ-038 br_type=6 with ex_valid=1 and branch=1 -> take_branch=0, no BHT change, counts unchanged; rst asserted together with a resolve -> no update occurs.
REQ-039 With CNT_W=4, apply 20 mispredicting resolves -> br_count=mp_count=15 (saturated, no wrap).
